// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: double-buffered three-channel PWM for the active-low RGB LED.
// New duties are swapped in only at PWM period boundaries, so a period never tears.
module rgb_pwm_driver #(
    parameter int DUTY_W   = 5,
    parameter int PRESCALE = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_r,
    input  logic [DUTY_W-1:0] duty_g,
    input  logic [DUTY_W-1:0] duty_b,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              enable,
    output logic              period_start,
    output logic [2:0]        led
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] STEP_LAST = '1;

    logic [PS_W-1:0]   prescale_cnt;
    logic [DUTY_W-1:0] step_cnt;
    logic              step_tick;
    logic              boundary;
    logic              accept;
    logic              pending_full;
    logic [DUTY_W-1:0] act_r, act_g, act_b;
    logic [DUTY_W-1:0] pend_r, pend_g, pend_b;
    logic [2:0]        chan_on;

    // >= rather than == so any unused prescaler encoding falls back to 0
    assign step_tick  = (prescale_cnt >= PS_LAST);
    assign boundary   = step_tick && (step_cnt == STEP_LAST);
    assign duty_ready = !pending_full;
    assign accept     = duty_valid && duty_ready;
    assign chan_on    = {step_cnt < act_r, step_cnt < act_b, step_cnt < act_g};

    // Free-running prescaler and PWM step counter, independent of enable
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_cnt <= '0;
            step_cnt     <= '0;
        end else if (step_tick) begin
            prescale_cnt <= '0;
            step_cnt     <= step_cnt + 1'b1;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

    // Pending buffer fills on handshake and drains into active at a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_full <= 1'b0;
            pend_r       <= '0;
            pend_g       <= '0;
            pend_b       <= '0;
            act_r        <= '0;
            act_g        <= '0;
            act_b        <= '0;
        end else begin
            if (boundary && pending_full) begin
                act_r        <= pend_r;
                act_g        <= pend_g;
                act_b        <= pend_b;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pend_r       <= duty_r;
                pend_g       <= duty_g;
                pend_b       <= duty_b;
                pending_full <= 1'b1;
            end
        end
    end

    // Registered LED drive (active-low {R,B,G}) and period start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            led          <= 3'b111;
            period_start <= 1'b0;
        end else begin
            led          <= ~(chan_on & {3{enable}});
            period_start <= boundary;
        end
    end

endmodule
